// File: rtl/cic_comb_cascade.sv
// N-stage pipelined CIC comb section with per-channel M-deep history,
// valid/channel tagging and a synchronous history clear.
module cic_comb_cascade #(
  parameter int unsigned IW = 19,
  parameter int unsigned OW = 19,
  parameter int unsigned N  = 3,
  parameter int unsigned M  = 1,
  parameter int unsigned C  = 4,
  parameter int unsigned CW = 2
) (
  input  logic          lr_clock,
  input  logic          reset_n,
  input  logic          i_valid,
  input  logic [IW-1:0] i_data,
  input  logic [CW-1:0] i_chan,
  input  logic          i_clear,
  output logic          o_valid,
  output logic [OW-1:0] o_data,
  output logic [CW-1:0] o_chan
);

  logic                   chan_ok;
  logic [OW-1:0]          entry_data;
  logic [N-1:0]           v_pipe;
  logic [N-1:0][CW-1:0]   c_pipe;
  logic [N-1:0][OW-1:0]   d_pipe;

  // Out-of-range channel tags are treated as bubbles.
  assign chan_ok    = (32'(i_chan) < C);
  assign entry_data = OW'($signed(i_data));

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic          in_v;
    logic [CW-1:0] in_c;
    logic [OW-1:0] in_d;
    logic [OW-1:0] tail;
    logic          valid_q;
    logic [CW-1:0] chan_q;
    logic [OW-1:0] data_q;
    logic [OW-1:0] hist [C][M];

    if (k == 0) begin : g_entry
      assign in_v = i_valid && chan_ok;
      assign in_c = i_chan;
      assign in_d = entry_data;
    end else begin : g_chain
      assign in_v = v_pipe[k-1];
      assign in_c = c_pipe[k-1];
      assign in_d = d_pipe[k-1];
    end

    // Oldest history entry (x[n-M]) of the channel currently in this stage.
    always_comb begin
      tail = '0;
      for (int c = 0; c < C; c++) begin
        if (in_c == CW'(c)) tail = hist[c][M-1];
      end
    end

    always_ff @(posedge lr_clock or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        chan_q  <= '0;
        data_q  <= '0;
        for (int c = 0; c < C; c++)
          for (int m = 0; m < M; m++)
            hist[c][m] <= '0;
      end else if (i_clear) begin
        valid_q <= 1'b0;
        for (int c = 0; c < C; c++)
          for (int m = 0; m < M; m++)
            hist[c][m] <= '0;
      end else begin
        valid_q <= in_v;
        if (in_v) begin
          data_q <= in_d - tail;
          chan_q <= in_c;
          // Only the active channel's delay line advances.
          for (int c = 0; c < C; c++) begin
            if (in_c == CW'(c)) begin
              for (int m = M - 1; m > 0; m--) hist[c][m] <= hist[c][m-1];
              hist[c][0] <= in_d;
            end
          end
        end
      end
    end

    assign v_pipe[k] = valid_q;
    assign c_pipe[k] = chan_q;
    assign d_pipe[k] = data_q;
  end

  assign o_valid = v_pipe[N-1];
  assign o_chan  = c_pipe[N-1];
  assign o_data  = d_pipe[N-1];

endmodule

// File: tb/tb_cic_comb_cascade.sv
// Directed bench for cic_comb_cascade: several parameterisations share one
// input bus; each scenario is checked on the instance it targets.
module tb_cic_comb_cascade;

  logic        clk;
  logic        reset_n;
  logic        i_valid;
  logic [18:0] i_data;
  logic [1:0]  i_chan;
  logic        i_clear;

  int checks;
  int errors;

  logic        ua_v, ub_v, uc_v, ud_v, ue_v, uf_v;
  logic [18:0] ua_d, ub_d, uc_d, ue_d, uf_d;
  logic [3:0]  ud_d;
  logic [1:0]  ua_c, ub_c, uc_c, ud_c, ue_c, uf_c;

  logic [18:0] step_exp [6];
  logic [7:0]  ue_vin;
  logic [7:0]  ue_vexp;
  logic [18:0] ue_dexp [8];

  // N=3 M=1 C=1
  cic_comb_cascade #(.IW(19), .OW(19), .N(3), .M(1), .C(1), .CW(2)) ua (
    .lr_clock(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data),
    .i_chan(i_chan), .i_clear(i_clear), .o_valid(ua_v), .o_data(ua_d), .o_chan(ua_c));
  // N=1 M=2 C=1
  cic_comb_cascade #(.IW(19), .OW(19), .N(1), .M(2), .C(1), .CW(2)) ub (
    .lr_clock(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data),
    .i_chan(i_chan), .i_clear(i_clear), .o_valid(ub_v), .o_data(ub_d), .o_chan(ub_c));
  // N=1 M=1 C=2
  cic_comb_cascade #(.IW(19), .OW(19), .N(1), .M(1), .C(2), .CW(2)) uc (
    .lr_clock(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data),
    .i_chan(i_chan), .i_clear(i_clear), .o_valid(uc_v), .o_data(uc_d), .o_chan(uc_c));
  // 4-bit wrap
  cic_comb_cascade #(.IW(4), .OW(4), .N(1), .M(1), .C(1), .CW(2)) ud (
    .lr_clock(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data[3:0]),
    .i_chan(i_chan), .i_clear(i_clear), .o_valid(ud_v), .o_data(ud_d), .o_chan(ud_c));
  // N=2 M=1 C=1
  cic_comb_cascade #(.IW(19), .OW(19), .N(2), .M(1), .C(1), .CW(2)) ue (
    .lr_clock(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data),
    .i_chan(i_chan), .i_clear(i_clear), .o_valid(ue_v), .o_data(ue_d), .o_chan(ue_c));
  // defaults: N=3 M=1 C=4
  cic_comb_cascade uf (
    .lr_clock(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data),
    .i_chan(i_chan), .i_clear(i_clear), .o_valid(uf_v), .o_data(uf_d), .o_chan(uf_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [18:0] d, input logic [1:0] ch);
    i_valid = v;
    i_data  = d;
    i_chan  = ch;
    tick();
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    drive(1'b0, 19'd0, 2'd0);
    i_clear = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 19'd0, 2'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_chan  = '0;
    i_clear = 1'b0;
    step_exp = '{19'd1, 19'h7FFFE, 19'd1, 19'd0, 19'd0, 19'd0};
    ue_vin   = 8'b0010_0011;
    ue_vexp  = 8'b0100_0110;
    ue_dexp  = '{19'd0, 19'd2, 19'h7FFFE, 19'h7FFFE, 19'h7FFFE, 19'h7FFFE, 19'd0, 19'd0};

    // Reset state
    tick();
    tick();
    chk("rst_valid", 19'(uf_v), 19'd0);
    chk("rst_data",  uf_d,      19'd0);
    chk("rst_chan",  19'(uf_c), 19'd0);
    reset_n = 1'b1;
    tick();

    // Step into three single-delay combs: latency 3, then 1,-2,1,0...
    do_clear();
    for (int i = 0; i < 8; i++) begin
      drive(i < 6, 19'd1, 2'd0);
      if (i < 2) chk("step_latency", 19'(ua_v), 19'd0);
      else begin
        chk("step_valid", 19'(ua_v), 19'd1);
        chk("step_data",  ua_d, step_exp[i-2]);
      end
    end

    // Out-of-range channel is a bubble and leaves history alone
    do_clear();
    drive(1'b1, 19'd9, 2'd3);
    drive(1'b1, 19'd4, 2'd0);
    drive(1'b0, 19'd0, 2'd0);
    chk("badchan_valid", 19'(ua_v), 19'd0);
    drive(1'b0, 19'd0, 2'd0);
    chk("badchan_next_valid", 19'(ua_v), 19'd1);
    chk("badchan_next_data",  ua_d, 19'd4);

    // M=2: 5,9,4,10 -> 5,9,-1,1
    do_clear();
    drive(1'b1, 19'd5, 2'd0);  chk("m2_data0", ub_d, 19'd5);
    drive(1'b1, 19'd9, 2'd0);  chk("m2_data1", ub_d, 19'd9);
    drive(1'b1, 19'd4, 2'd0);  chk("m2_data2", ub_d, 19'h7FFFF);
    drive(1'b1, 19'd10, 2'd0); chk("m2_data3", ub_d, 19'd1);
    chk("m2_valid", 19'(ub_v), 19'd1);

    // Two interleaved channels with independent history
    do_clear();
    drive(1'b1, 19'd3, 2'd0);   chk("ch_data0", uc_d, 19'd3);   chk("ch_chan0", 19'(uc_c), 19'd0);
    drive(1'b1, 19'd100, 2'd1); chk("ch_data1", uc_d, 19'd100); chk("ch_chan1", 19'(uc_c), 19'd1);
    drive(1'b1, 19'd7, 2'd0);   chk("ch_data2", uc_d, 19'd4);   chk("ch_chan2", 19'(uc_c), 19'd0);
    drive(1'b1, 19'd90, 2'd1);  chk("ch_data3", uc_d, 19'h7FFF6); chk("ch_chan3", 19'(uc_c), 19'd1);

    // 4-bit wraparound: 7 then -8 -> 7, 1
    do_clear();
    drive(1'b1, 19'd7, 2'd0); chk("wrap_data0", 19'(ud_d), 19'd7);
    drive(1'b1, 19'd8, 2'd0); chk("wrap_data1", 19'(ud_d), 19'd1);
    chk("wrap_chan", 19'(ud_c), 19'd0);

    // Bubbles: 2,2,gap x3,2 through two combs -> 2,-2,0 with holds in between
    do_clear();
    for (int i = 0; i < 8; i++) begin
      drive(ue_vin[i], 19'd2, 2'd0);
      chk("bubble_valid", 19'(ue_v), 19'(ue_vexp[i]));
      if (i > 0) chk("bubble_data", ue_d, ue_dexp[i]);
    end

    // Clear mid-stream drops in-flight and same-cycle samples
    do_clear();
    drive(1'b1, 19'd1, 2'd2);
    drive(1'b1, 19'd2, 2'd2);
    drive(1'b1, 19'd3, 2'd2);
    chk("pre_clear_valid", 19'(uf_v), 19'd1);
    chk("pre_clear_data",  uf_d, 19'd1);
    i_clear = 1'b1;
    drive(1'b1, 19'd50, 2'd2);
    i_clear = 1'b0;
    chk("clear_gap0", 19'(uf_v), 19'd0);
    drive(1'b1, 19'd6, 2'd2);  chk("clear_gap1", 19'(uf_v), 19'd0);
    drive(1'b0, 19'd0, 2'd0);  chk("clear_gap2", 19'(uf_v), 19'd0);
    drive(1'b0, 19'd0, 2'd0);
    chk("clear_restart_valid", 19'(uf_v), 19'd1);
    chk("clear_restart_data",  uf_d, 19'd6);
    chk("clear_restart_chan",  19'(uf_c), 19'd2);

    // Asynchronous reset mid-stream
    do_clear();
    drive(1'b1, 19'd5, 2'd1);
    drive(1'b1, 19'd5, 2'd1);
    drive(1'b1, 19'd5, 2'd1);
    chk("pre_rst_data", uf_d, 19'd5);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 19'(uf_v), 19'd0);
    chk("async_rst_data",  uf_d, 19'd0);
    chk("async_rst_chan",  19'(uf_c), 19'd0);
    i_clear = 1'b1;
    drive(1'b1, 19'd7, 2'd1);
    i_clear = 1'b0;
    chk("rst_hold_valid", 19'(uf_v), 19'd0);
    reset_n = 1'b1;
    drive(1'b1, 19'd6, 2'd1); chk("rst_gap0", 19'(uf_v), 19'd0);
    drive(1'b0, 19'd0, 2'd0); chk("rst_gap1", 19'(uf_v), 19'd0);
    drive(1'b0, 19'd0, 2'd0);
    chk("rst_restart_valid", 19'(uf_v), 19'd1);
    chk("rst_restart_data",  uf_d, 19'd6);
    chk("rst_restart_chan",  19'(uf_c), 19'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
